array_flatten_serializer: RTL and testbench
===========================================

// Module: array_flatten_serializer
// PURPOSE
//   Accepts an N-element unpacked array of W-bit words with a valid/ready handshake.
//   Flattens it element-major: element k occupies flat[k*W +: W].
//   Streams the flat vector out as N/LANES beats of LANES*W bits each.
//   Sits between array-typed instance ports and narrower packed datapaths.
//   Generalises the fixed 5x5 array<->25-bit flattening with width, depth, lane
//   count, order and backpressure.
// PARAMETERS
//   W      5  bits per array element (>=1)
//   N      5  number of array elements (>=1)
//   LANES  1  elements per output beat; N % LANES == 0 (elaboration error otherwise)
//   ORDER  0  0: beat 0 carries elements 0..LANES-1; 1: beat 0 carries N-LANES..N-1
// PORTS
//   CLK         in   1             rising-edge clock
//   ASYNCRESET  in   1             asynchronous, active-high reset
//   I           in   [W-1:0] x N   unpacked input array I[N-1:0]
//   I_valid     in   1             input array valid
//   I_ready     out  1             block can capture I this cycle
//   O           out  LANES*W       current output beat (registered)
//   O_valid     out  1             O holds a valid beat
//   O_ready     in   1             downstream accepts beat
//   O_last      out  1             current beat is the final beat of the array
//   O_beat      out  clog2(N/LANES) (min 1)  index of current beat, 0-based
// BEHAVIOUR
//   Constant: BEATS = N/LANES.
//   Capture register: X[N*W-1:0] = {I[N-1],...,I[0]}.
//   FSM: IDLE, SEND.
//   Reset (ASYNCRESET high, immediate):
//     state=IDLE; X=0; beat counter=0.
//     O=0, O_valid=0, O_last=0, O_beat=0. I_ready=0 while reset is held.
//   I_ready (combinational): (state==IDLE) || (O_valid && O_ready && O_last).
//   Capture: on I_valid && I_ready at edge t:
//     load X; beat=0; state=SEND.
//     O_valid=1 from t+1, with beat 0 on O. Latency = 1 cycle.
//   Beat b slice:
//     ORDER=0: O = X[b*LANES*W +: LANES*W].
//     ORDER=1: O = X[(BEATS-1-b)*LANES*W +: LANES*W].
//     Elements within a beat keep ascending index order (lowest element at LSBs).
//   Advance: on O_valid && O_ready with !O_last, beat++ and O updates next cycle.
//   Stall: while O_valid && !O_ready, O, O_beat and O_last are held stable.
//   O_last = O_valid && (beat == BEATS-1).
//   Final beat accepted, no new capture: state=IDLE; O_valid=0 next cycle; O holds.
//   Final beat accepted with I_valid in the same cycle (back-to-back):
//     capture the new array; beat=0; O_valid stays 1; no bubble.
//   BEATS==1: every beat has O_last=1; one array per cycle is sustainable.
//   I changes while not captured: ignored. X is never modified mid-SEND.
//   O_ready while O_valid=0: ignored.
//   Reset asserted mid-SEND: the in-flight array is discarded and no beats are
//     emitted after reset release until a new capture.
// TESTING (default W=5,N=5 unless stated; I[k]=k+1)
//   1 LANES=1, O_ready=1, single capture:
//     O=1,2,3,4,5 on cycles t+1..t+5; O_last only with 5; O_valid=0 at t+6.
//   2 LANES=5: one beat O=25'h520C41 ({5,4,3,2,1}), O_last=1, O_beat=0.
//     Continuous I_valid gives one array per cycle.
//   3 LANES=1, O_ready low for 3 cycles on beat 2:
//     O stays 3, O_beat stays 2, I_ready=0 throughout; then 4,5 follow.
//   4 Back-to-back: second array I[k]=k+11 valid when beat 5 is accepted.
//     Next cycle O=11 with O_valid continuous and I_ready pulsed exactly once.
//   5 ORDER=1, LANES=1: beat sequence 5,4,3,2,1; O_beat 0..4.
//   6 ASYNCRESET pulsed mid-cycle after beat 2:
//     O_valid/O/O_last go 0 immediately; I_ready=1 the first cycle after release.

Source files
------------

// File: rtl/array_flatten_serializer.sv
// array_flatten_serializer
// Captures an N-element array of W-bit words, flattens it element-major and
// streams it out as N/LANES beats of LANES*W bits with valid/ready on both sides.
module array_flatten_serializer #(
  parameter int unsigned W     = 5,
  parameter int unsigned N     = 5,
  parameter int unsigned LANES = 1,
  parameter int unsigned ORDER = 0
) (
  input  logic                                  CLK,
  input  logic                                  ASYNCRESET,
  input  logic [W-1:0]                          I [N-1:0],
  input  logic                                  I_valid,
  output logic                                  I_ready,
  output logic [LANES*W-1:0]                    O,
  output logic                                  O_valid,
  input  logic                                  O_ready,
  output logic                                  O_last,
  output logic [((N/LANES) > 1 ? $clog2(N/LANES) : 1)-1:0] O_beat
);

  localparam int unsigned BEATS  = N / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LW     = LANES * W;
  localparam int unsigned FW     = N * W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Reject lane counts that do not divide the array evenly
  if ((LANES == 0) || (N % LANES != 0)) begin : g_lanes_check
    $error("array_flatten_serializer: N must be a multiple of LANES");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e            state_q;
  logic [FW-1:0]     x_q;
  logic [BEAT_W-1:0] beat_q;
  logic [LW-1:0]     o_q;
  logic              o_valid_q;
  logic              o_last_q;

  logic [FW-1:0]     i_flat;
  logic              capture;
  logic              out_accept;
  logic              final_accept;
  logic [BEAT_W-1:0] beat_next;

  // Select the bits of beat b from a flattened vector, honouring beat order
  function automatic logic [LW-1:0] beat_slice(input logic [FW-1:0] vec,
                                               input logic [BEAT_W-1:0] b);
    logic [BEAT_W-1:0] idx;
    int unsigned       base;
    idx  = (ORDER != 0) ? (LAST_BEAT - b) : b;
    base = 32'(idx) * LW;
    return vec[base +: LW];
  endfunction

  // Element-major flattening: element k lands at [k*W +: W]
  always_comb begin
    i_flat = '0;
    for (int unsigned k = 0; k < N; k++) begin
      i_flat[k*W +: W] = I[k];
    end
  end

  // Handshake decode; a new array may be taken while the final beat leaves
  always_comb begin
    I_ready      = !ASYNCRESET &&
                   ((state_q == IDLE) || (o_valid_q && O_ready && o_last_q));
    capture      = I_valid && I_ready;
    out_accept   = o_valid_q && O_ready;
    final_accept = out_accept && o_last_q;
    beat_next    = beat_q + BEAT_W'(1);
  end

  // Capture / beat-advance FSM with registered output beat
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q   <= IDLE;
      x_q       <= '0;
      beat_q    <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else if (capture) begin
      state_q   <= SEND;
      x_q       <= i_flat;
      beat_q    <= '0;
      o_q       <= beat_slice(i_flat, '0);
      o_valid_q <= 1'b1;
      o_last_q  <= (BEATS == 1);
    end else if (final_accept) begin
      state_q   <= IDLE;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else if (out_accept) begin
      beat_q    <= beat_next;
      o_q       <= beat_slice(x_q, beat_next);
      o_last_q  <= (beat_next == LAST_BEAT);
    end
  end

  assign O       = o_q;
  assign O_valid = o_valid_q;
  assign O_last  = o_last_q;
  assign O_beat  = beat_q;

endmodule

// File: tb/tb_array_flatten_serializer.sv
// Directed bench for array_flatten_serializer: three instances cover
// LANES=1/ORDER=0, LANES=5 (single beat) and LANES=1/ORDER=1.
module tb_array_flatten_serializer;

  logic       clk;
  logic       rst;
  logic [4:0] arr [4:0];

  logic        a_ivalid, a_iready, a_ovalid, a_oready, a_olast;
  logic [4:0]  a_o;
  logic [2:0]  a_beat;

  logic        b_ivalid, b_iready, b_ovalid, b_oready, b_olast;
  logic [24:0] b_o;
  logic [0:0]  b_beat;

  logic        c_ivalid, c_iready, c_ovalid, c_oready, c_olast;
  logic [4:0]  c_o;
  logic [2:0]  c_beat;

  int n_chk;
  int n_fail;
  int pulses;

  array_flatten_serializer #(.W(5), .N(5), .LANES(1), .ORDER(0)) u_a (
    .CLK(clk), .ASYNCRESET(rst), .I(arr), .I_valid(a_ivalid), .I_ready(a_iready),
    .O(a_o), .O_valid(a_ovalid), .O_ready(a_oready), .O_last(a_olast), .O_beat(a_beat)
  );

  array_flatten_serializer #(.W(5), .N(5), .LANES(5), .ORDER(0)) u_b (
    .CLK(clk), .ASYNCRESET(rst), .I(arr), .I_valid(b_ivalid), .I_ready(b_iready),
    .O(b_o), .O_valid(b_ovalid), .O_ready(b_oready), .O_last(b_olast), .O_beat(b_beat)
  );

  array_flatten_serializer #(.W(5), .N(5), .LANES(1), .ORDER(1)) u_c (
    .CLK(clk), .ASYNCRESET(rst), .I(arr), .I_valid(c_ivalid), .I_ready(c_iready),
    .O(c_o), .O_valid(c_ovalid), .O_ready(c_oready), .O_last(c_olast), .O_beat(c_beat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_arr(input int base);
    for (int k = 0; k < 5; k++) arr[k] = 5'(k + base);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    pulses   = 0;
    rst      = 1'b1;
    a_ivalid = 1'b0; a_oready = 1'b0;
    b_ivalid = 1'b0; b_oready = 1'b0;
    c_ivalid = 1'b0; c_oready = 1'b0;
    set_arr(1);

    // Reset state
    tick();
    check("rst_a_iready", 64'(a_iready), 64'd0);
    check("rst_b_iready", 64'(b_iready), 64'd0);
    check("rst_a_ovalid", 64'(a_ovalid), 64'd0);
    check("rst_a_o",      64'(a_o),      64'd0);
    check("rst_a_olast",  64'(a_olast),  64'd0);
    check("rst_a_beat",   64'(a_beat),   64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_a_iready", 64'(a_iready), 64'd1);

    // 1: LANES=1 single capture, beats 1..5
    a_ivalid = 1'b1; a_oready = 1'b1;
    tick();
    a_ivalid = 1'b0;
    for (int b = 0; b < 5; b++) begin
      check($sformatf("t1_o%0d", b),     64'(a_o),      64'(b + 1));
      check($sformatf("t1_beat%0d", b),  64'(a_beat),   64'(b));
      check($sformatf("t1_last%0d", b),  64'(a_olast),  64'(b == 4));
      check($sformatf("t1_valid%0d", b), 64'(a_ovalid), 64'd1);
      tick();
    end
    check("t1_valid_end", 64'(a_ovalid), 64'd0);
    check("t1_o_hold",    64'(a_o),      64'd5);

    // 3: stall three cycles on beat 2
    a_ivalid = 1'b1;
    tick();
    a_ivalid = 1'b0;
    tick();
    tick();
    a_oready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("t3_o_s%0d", s),      64'(a_o),      64'd3);
      check($sformatf("t3_beat_s%0d", s),   64'(a_beat),   64'd2);
      check($sformatf("t3_iready_s%0d", s), 64'(a_iready), 64'd0);
      tick();
    end
    check("t3_o_held", 64'(a_o), 64'd3);
    a_oready = 1'b1;
    tick();
    check("t3_o4", 64'(a_o), 64'd4);
    tick();
    check("t3_o5",    64'(a_o),     64'd5);
    check("t3_last5", 64'(a_olast), 64'd1);
    tick();
    check("t3_valid_end", 64'(a_ovalid), 64'd0);

    // 4: back-to-back, second array offered as beat 5 leaves
    a_ivalid = 1'b1;
    tick();
    a_ivalid = 1'b0;
    for (int b = 0; b < 5; b++) begin
      if (b == 4) begin
        set_arr(11);
        a_ivalid = 1'b1;
        check("t4_iready_last", 64'(a_iready), 64'd1);
      end
      if (a_iready) pulses++;
      check($sformatf("t4_valid%0d", b), 64'(a_ovalid), 64'd1);
      tick();
    end
    a_ivalid = 1'b0;
    if (a_iready) pulses++;
    check("t4_o11",     64'(a_o),      64'd11);
    check("t4_valid2",  64'(a_ovalid), 64'd1);
    check("t4_beat0",   64'(a_beat),   64'd0);
    check("t4_pulses",  64'(pulses),   64'd1);
    for (int b = 1; b < 5; b++) begin
      tick();
      check($sformatf("t4_o2_%0d", b), 64'(a_o), 64'(b + 11));
    end
    tick();
    check("t4_valid_end", 64'(a_ovalid), 64'd0);

    // 2: LANES=5, one array per cycle
    set_arr(1);
    b_ivalid = 1'b1; b_oready = 1'b1;
    check("t2_iready0", 64'(b_iready), 64'd1);
    tick();
    check("t2_o_a",    64'(b_o),     64'h520C41);
    check("t2_last_a", 64'(b_olast), 64'd1);
    check("t2_beat_a", 64'(b_beat),  64'd0);
    set_arr(11);
    check("t2_iready1", 64'(b_iready), 64'd1);
    tick();
    check("t2_o_b",     64'(b_o),      64'hF7358B);
    check("t2_valid_b", 64'(b_ovalid), 64'd1);
    set_arr(21);
    tick();
    check("t2_o_c", 64'(b_o), 64'h19C5ED5);
    b_ivalid = 1'b0;
    tick();
    check("t2_valid_end", 64'(b_ovalid), 64'd0);
    check("t2_o_hold",    64'(b_o),      64'h19C5ED5);

    // 5: ORDER=1 reverses beat order
    set_arr(1);
    c_ivalid = 1'b1; c_oready = 1'b1;
    tick();
    c_ivalid = 1'b0;
    for (int b = 0; b < 5; b++) begin
      check($sformatf("t5_o%0d", b),    64'(c_o),     64'(5 - b));
      check($sformatf("t5_beat%0d", b), 64'(c_beat),  64'(b));
      check($sformatf("t5_last%0d", b), 64'(c_olast), 64'(b == 4));
      tick();
    end
    check("t5_valid_end", 64'(c_ovalid), 64'd0);

    // 6: asynchronous reset mid-SEND
    a_ivalid = 1'b1; a_oready = 1'b1;
    tick();
    a_ivalid = 1'b0;
    tick();
    tick();
    check("t6_o_pre", 64'(a_o), 64'd3);
    #2 rst = 1'b1;
    #1;
    check("t6_valid_rst", 64'(a_ovalid), 64'd0);
    check("t6_o_rst",     64'(a_o),      64'd0);
    check("t6_last_rst",  64'(a_olast),  64'd0);
    check("t6_iready_rst", 64'(a_iready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t6_iready_rel", 64'(a_iready), 64'd1);
    tick();
    check("t6_valid_rel1", 64'(a_ovalid), 64'd0);
    tick();
    check("t6_valid_rel2", 64'(a_ovalid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
